bus_width_converter: RTL

Parametrised successor to the fixed 8→32 packer: converts a ready/valid stream between any two bus widths whose ratio is an integer, in either direction (upsize, downsize or equal-width pass-through). Adds backpressure on both sides, a packet `last` marker that flushes partial words, and per-lane keep masks. Sits between FIFOs or datapath stages whose widths differ.

---
 rtl/bus_width_converter_if.sv | 32 +++
 rtl/bus_width_converter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_width_converter_if.sv
// Ready/valid stream bundle seen by bus_width_converter.
// The slave modport is the converter's view and the master modport is the
// environment's view (it drives the input side and consumes the output side).
interface bus_width_converter_if #(
  parameter int SIZE_IN  = 8,
  parameter int SIZE_OUT = 32
);
  localparam int LANE = (SIZE_IN < SIZE_OUT) ? SIZE_IN : SIZE_OUT;
  localparam int KI   = SIZE_IN / LANE;
  localparam int KO   = SIZE_OUT / LANE;

  logic                valid_in;
  logic                ready_in;
  logic [SIZE_IN-1:0]  in;
  logic [KI-1:0]       keep_in;
  logic                last_in;
  logic                valid_out;
  logic                ready_out;
  logic [SIZE_OUT-1:0] out;
  logic [KO-1:0]       keep_out;
  logic                last_out;

  modport slave (
    input  valid_in, in, keep_in, last_in, ready_out,
    output ready_in, valid_out, out, keep_out, last_out
  );

  modport master (
    output valid_in, in, keep_in, last_in, ready_out,
    input  ready_in, valid_out, out, keep_out, last_out
  );
endinterface

// File: rtl/bus_width_converter.sv
// Ready/valid stream width converter for integer width ratios.
// Upsizing packs little-endian lanes into an output word (flushed early on
// last_in), downsizing serialises the low-aligned kept lanes of an input word,
// and equal widths collapse to a one-stage register slice.
module bus_width_converter #(
  parameter int SIZE_IN  = 8,
  parameter int SIZE_OUT = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_width_converter_if.slave bus
);
  localparam int LANE  = (SIZE_IN < SIZE_OUT) ? SIZE_IN : SIZE_OUT;
  localparam int MAXW  = (SIZE_IN < SIZE_OUT) ? SIZE_OUT : SIZE_IN;
  localparam int RATIO = MAXW / LANE;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // active_q keeps ready_in low during reset and goes high on the first edge
  // after release, so no beat is accepted while the state is being cleared.
  logic active_q;
  logic active_d;

  // Next value of the accept enable.
  always_comb begin
    active_d = 1'b1;
  end

  // Accept enable register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) active_q <= 1'b0;
    else        active_q <= active_d;
  end

  if (SIZE_OUT > SIZE_IN) begin : g_up
    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SIZE_OUT-1:0] out_q, out_d;
    logic [RATIO-1:0]    keep_q, keep_d;
    logic                last_q, last_d;
    logic                ready;
    logic                in_fire;
    logic                out_fire;

    // The accumulator doubles as the output register; a new word may start
    // only when the held word is absent or draining this cycle.
    assign ready    = active_q && ((state_q != HOLD) || bus.ready_out);
    assign in_fire  = bus.valid_in && ready;
    assign out_fire = (state_q == HOLD) && bus.ready_out;

    // Packing: clear on drain, then drop the accepted beat into lane cnt.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      keep_d  = keep_q;
      last_d  = last_q;
      if (out_fire) begin
        state_d = EMPTY;
        out_d   = '0;
        keep_d  = '0;
        last_d  = 1'b0;
      end
      if (in_fire) begin
        for (int i = 0; i < RATIO; i++) begin
          if (cnt_q == CW'(i)) begin
            out_d[i*LANE +: LANE] = bus.in;
            keep_d[i]             = 1'b1;
          end
        end
        if ((cnt_q == CW'(RATIO - 1)) || bus.last_in) begin
          state_d = HOLD;
          last_d  = bus.last_in;
          cnt_d   = '0;
        end else begin
          state_d = FILL;
          cnt_d   = cnt_q + CW'(1);
        end
      end
    end

    // Packing state registers.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= EMPTY;
        cnt_q   <= '0;
        out_q   <= '0;
        keep_q  <= '0;
        last_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
        keep_q  <= keep_d;
        last_q  <= last_d;
      end
    end

    assign bus.ready_in  = ready;
    assign bus.valid_out = (state_q == HOLD);
    assign bus.out       = out_q;
    assign bus.keep_out  = keep_q;
    assign bus.last_out  = last_q;

  end else if (SIZE_IN > SIZE_OUT) begin : g_down
    localparam int NW = $clog2(RATIO + 1);

    state_e             state_q, state_d;
    logic [NW-1:0]      n_q, n_d;
    logic [SIZE_IN-1:0] hold_q, hold_d;
    logic               last_q, last_d;
    logic [NW-1:0]      n_load;
    logic               run;
    logic               ready;
    logic               in_fire;
    logic               out_fire;

    // Reload is allowed when empty or when the final lane leaves this cycle.
    assign ready    = active_q && ((n_q == '0) || ((n_q == NW'(1)) && bus.ready_out));
    assign in_fire  = bus.valid_in && ready;
    assign out_fire = (state_q == HOLD) && bus.ready_out;

    // Lane count of a new beat: contiguous keep bits from lane 0 upward.
    always_comb begin
      n_load = '0;
      run    = 1'b1;
      for (int i = 0; i < RATIO; i++) begin
        if (run && bus.keep_in[i]) n_load = n_load + NW'(1);
        else                       run    = 1'b0;
      end
    end

    // Serialisation: shift one lane per output transfer, reload on accept.
    always_comb begin
      state_d = state_q;
      n_d     = n_q;
      hold_d  = hold_q;
      last_d  = last_q;
      if (out_fire) begin
        hold_d = hold_q >> LANE;
        n_d    = n_q - NW'(1);
        if (n_q == NW'(1)) state_d = EMPTY;
      end
      if (in_fire) begin
        hold_d  = bus.in;
        n_d     = n_load;
        last_d  = bus.last_in;
        state_d = (n_load != '0) ? HOLD : EMPTY;
      end
    end

    // Serialisation state registers.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= EMPTY;
        n_q     <= '0;
        hold_q  <= '0;
        last_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        n_q     <= n_d;
        hold_q  <= hold_d;
        last_q  <= last_d;
      end
    end

    assign bus.ready_in  = ready;
    assign bus.valid_out = (state_q == HOLD);
    assign bus.out       = hold_q[LANE-1:0];
    assign bus.keep_out  = active_q ? '1 : '0;
    assign bus.last_out  = last_q && (n_q == NW'(1));

  end else begin : g_pass
    logic [LANE-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            ready;
    logic            in_fire;
    logic            out_fire;

    assign ready    = active_q && (!valid_q || bus.ready_out);
    assign in_fire  = bus.valid_in && ready;
    assign out_fire = valid_q && bus.ready_out;

    // Register slice: drop the held beat on drain, capture on accept.
    always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      if (out_fire) valid_d = 1'b0;
      if (in_fire) begin
        data_d  = bus.in;
        last_d  = bus.last_in;
        valid_d = 1'b1;
      end
    end

    // Register slice storage.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data_q  <= '0;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
        last_q  <= last_d;
      end
    end

    assign bus.ready_in  = ready;
    assign bus.valid_out = valid_q;
    assign bus.out       = data_q;
    assign bus.keep_out  = active_q ? '1 : '0;
    assign bus.last_out  = last_q && valid_q;
  end
endmodule
